ni_param: RTL

- Parametrised next-generation GPU network interface. It sits between one GPU port and its leaf router in the grouped NoC.
- GPU→router path: rewrites the destination GPU ID in the header into the group/leaf routing address arithmetically, then buffers the flit.
- Router→GPU path: filters flits by own address, restores the GPU ID and buffers the flit.
- Adds over the previous NI: true valid/ready on all four interfaces with data held under backpressure, router-side backpressure, drop of bad-destination and misrouted flits with counters, and optional local loopback.

---
 rtl/ni_param.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ni_param.sv
// ni_param: GPU <-> leaf-router network interface with address rewrite, filtering, drop counters and loopback
module ni_param #(
   parameter int GPU_ID      = 18,
   parameter int NUM_GPUS    = 32,
   parameter int DATA_W      = 16,
   parameter int HEADER_W    = 6,
   parameter int ADDR_OFFSET = 3,
   parameter int FIFO_DEPTH  = 8,
   parameter int CNT_W       = 8,
   parameter int LOOPBACK    = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] gpu_data_in,
   input  logic              gpu_valid_in,
   output logic              gpu_ready_out,
   output logic [DATA_W-1:0] gpu_data_out,
   output logic              gpu_valid_out,
   input  logic              gpu_ready_in,
   output logic [DATA_W-1:0] router_data_out,
   output logic              router_valid_out,
   input  logic              router_ready_in,
   input  logic [DATA_W-1:0] router_data_in,
   input  logic              router_valid_in,
   output logic              router_ready_out,
   output logic [CNT_W-1:0]  drop_baddest_cnt,
   output logic [CNT_W-1:0]  drop_misroute_cnt
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = DATA_W - HEADER_W;
   localparam logic [HEADER_W-1:0] OWN_ADDR = HEADER_W'(GPU_ID + ADDR_OFFSET);
   localparam logic [HEADER_W-1:0] OWN_ID = HEADER_W'(GPU_ID);

   logic              rdy_en;
   logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
   logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
   logic [AW-1:0]     tx_wp, tx_rp, rx_wp, rx_rp;
   logic [AW:0]       tx_cnt, rx_cnt;
   logic [HEADER_W-1:0] dest;
   logic [DATA_W-1:0] tx_wdata, rx_wdata, tx_head, rx_head;
   logic              dest_ok, tx_full, tx_empty, rx_full, rx_empty;
   logic              tx_wr, tx_rd, rx_wr, rx_rd, bad_drop, mis_drop;
   logic              head_self, rx_match, rx_acc, to_router, to_loop;

   // handshake qualifiers, header rewrite/restore and loopback arbitration (router write wins)
   always_comb begin
      tx_full          = tx_cnt[AW];
      tx_empty         = tx_cnt == '0;
      rx_full          = rx_cnt[AW];
      rx_empty         = rx_cnt == '0;
      gpu_ready_out    = rdy_en && !tx_full;
      router_ready_out = rdy_en && !rx_full;
      dest             = gpu_data_in[DATA_W-1 -: HEADER_W];
      dest_ok          = dest != '0 && 32'(dest) <= 32'(NUM_GPUS);
      tx_wdata         = {HEADER_W'(32'(dest) + 32'(ADDR_OFFSET)), gpu_data_in[PW-1:0]};
      tx_wr            = gpu_valid_in && gpu_ready_out && dest_ok;
      bad_drop         = gpu_valid_in && gpu_ready_out && !dest_ok;
      tx_head          = tx_mem[tx_rp];
      rx_head          = rx_mem[rx_rp];
      head_self        = LOOPBACK != 0 && tx_head[DATA_W-1 -: HEADER_W] == OWN_ADDR;
      rx_match         = router_data_in[DATA_W-1 -: HEADER_W] == OWN_ADDR;
      rx_acc           = router_valid_in && router_ready_out && rx_match;
      mis_drop         = router_valid_in && router_ready_out && !rx_match;
      to_router        = !tx_empty && !head_self && (!router_valid_out || router_ready_in);
      to_loop          = !tx_empty && head_self && !rx_full && !rx_acc;
      tx_rd            = to_router || to_loop;
      rx_wr            = rx_acc || to_loop;
      rx_wdata         = {OWN_ID, rx_acc ? router_data_in[PW-1:0] : tx_head[PW-1:0]};
      rx_rd            = !rx_empty && (!gpu_valid_out || gpu_ready_in);
   end

   // ready outputs stay low through reset and rise on the first clock after release
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) rdy_en <= 1'b0;
      else rdy_en <= 1'b1;

   // FIFO storage needs no reset; occupancy is tracked by the pointers and counts
   always_ff @(posedge clk) begin
      if (tx_wr) tx_mem[tx_wp] <= tx_wdata;
      if (rx_wr) rx_mem[rx_wp] <= rx_wdata;
   end

   // FIFO pointers and counts; a simultaneous read and write keeps the count
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         tx_wp  <= '0;
         tx_rp  <= '0;
         tx_cnt <= '0;
         rx_wp  <= '0;
         rx_rp  <= '0;
         rx_cnt <= '0;
      end else begin
         if (tx_wr) tx_wp <= tx_wp + 1'b1;
         if (tx_rd) tx_rp <= tx_rp + 1'b1;
         if (rx_wr) rx_wp <= rx_wp + 1'b1;
         if (rx_rd) rx_rp <= rx_rp + 1'b1;
         tx_cnt <= tx_cnt + (AW+1)'(tx_wr) - (AW+1)'(tx_rd);
         rx_cnt <= rx_cnt + (AW+1)'(rx_wr) - (AW+1)'(rx_rd);
      end

   // output registers load the FIFO head when empty or being accepted, otherwise hold
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         router_valid_out <= 1'b0;
         router_data_out  <= '0;
         gpu_valid_out    <= 1'b0;
         gpu_data_out     <= '0;
      end else begin
         if (to_router) begin
            router_valid_out <= 1'b1;
            router_data_out  <= tx_head;
         end else if (router_ready_in) router_valid_out <= 1'b0;
         if (rx_rd) begin
            gpu_valid_out <= 1'b1;
            gpu_data_out  <= rx_head;
         end else if (gpu_ready_in) gpu_valid_out <= 1'b0;
      end

   // saturating drop counters, independent so both can count in one cycle
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         drop_baddest_cnt  <= '0;
         drop_misroute_cnt <= '0;
      end else begin
         if (bad_drop && drop_baddest_cnt != '1) drop_baddest_cnt <= drop_baddest_cnt + 1'b1;
         if (mis_drop && drop_misroute_cnt != '1) drop_misroute_cnt <= drop_misroute_cnt + 1'b1;
      end
endmodule
